// File: rtl/alu_op_issue.sv
// ID/EX boundary register for the ALU Operation code: decodes ALUOp/funct3/funct7,
// then registers opcode, branch flag, destination tag and an unsupported-encoding flag.
module alu_op_issue #(
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [1:0]                id_aluop,
  input  logic [2:0]                id_funct3,
  input  logic [6:0]                id_funct7,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      ex_valid,
  output logic [OPCODE_LENGTH-1:0]  ex_operation,
  output logic                      ex_is_branch,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_illegal,
  output logic [7:0]                illegal_count
);

  typedef logic [OPCODE_LENGTH-1:0] op_t;

  localparam op_t OP_AND = op_t'(4'b0000);
  localparam op_t OP_OR  = op_t'(4'b0001);
  localparam op_t OP_ADD = op_t'(4'b0010);
  localparam op_t OP_SUB = op_t'(4'b0011);
  localparam op_t OP_SLL = op_t'(4'b0100);
  localparam op_t OP_SRL = op_t'(4'b0101);
  localparam op_t OP_SRA = op_t'(4'b0111);
  localparam op_t OP_EQ  = op_t'(4'b1000);
  localparam op_t OP_NE  = op_t'(4'b1001);
  localparam op_t OP_BLT = op_t'(4'b1011);
  localparam op_t OP_XOR = op_t'(4'b1101);
  localparam op_t OP_BGE = op_t'(4'b1111);

  op_t  dec_op;
  logic dec_illegal;
  logic dec_branch;
  logic f7_zero;
  logic f7_alt;
  logic i_type;

  assign f7_zero = (id_funct7 == 7'b0000000);
  assign f7_alt  = (id_funct7 == 7'b0100000);
  assign i_type  = id_aluop[0];

  // Illegal encodings fall through with the default opcode (AND, 0000).
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    dec_op      = OP_AND;
    dec_illegal = 1'b0;
    dec_branch  = 1'b0;
    unique case (id_aluop)
      2'b00: dec_op = OP_ADD;
      2'b01: begin
        dec_branch = 1'b1;
        case (id_funct3)
          3'b000:  dec_op = OP_EQ;
          3'b001:  dec_op = OP_NE;
          3'b100:  dec_op = OP_BLT;
          3'b101:  dec_op = OP_BGE;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: begin
        // R-type (10) and I-type ALU (11); immediates occupy funct7 bits for I-type.
        case (id_funct3)
          3'b000: begin
            if (i_type || f7_zero) dec_op = OP_ADD;
            else if (f7_alt)       dec_op = OP_SUB;
            else                   dec_illegal = 1'b1;
          end
          3'b001: begin
            if (f7_zero) dec_op = OP_SLL;
            else         dec_illegal = 1'b1;
          end
          3'b100: begin
            if (i_type || f7_zero) dec_op = OP_XOR;
            else                   dec_illegal = 1'b1;
          end
          3'b101: begin
            if (f7_zero)     dec_op = OP_SRL;
            else if (f7_alt) dec_op = OP_SRA;
            else             dec_illegal = 1'b1;
          end
          3'b110: begin
            if (i_type || f7_zero) dec_op = OP_OR;
            else                   dec_illegal = 1'b1;
          end
          3'b111: begin
            if (i_type || f7_zero) dec_op = OP_AND;
            else                   dec_illegal = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  // Flush beats stall; an unstalled cycle without id_valid inserts a zeroed bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_operation <= '0;
      ex_is_branch <= 1'b0;
      ex_rd        <= '0;
      ex_illegal   <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_operation <= '0;
      ex_is_branch <= 1'b0;
      ex_rd        <= '0;
      ex_illegal   <= 1'b0;
    end else if (!stall) begin
      ex_valid     <= id_valid;
      ex_operation <= id_valid ? dec_op : '0;
      ex_is_branch <= id_valid & dec_branch;
      ex_rd        <= id_valid ? id_rd : '0;
      ex_illegal   <= id_valid & dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_count <= 8'd0;
    end else if (!flush && !stall && id_valid && dec_illegal && (illegal_count != 8'hFF)) begin
      illegal_count <= illegal_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: expected EX contents are queued when an
// instruction is driven and popped when the following edge has produced them.
module tb_alu_op_issue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [1:0] id_aluop;
  logic [2:0] id_funct3;
  logic [6:0] id_funct7;
  logic [4:0] id_rd;
  logic       stall;
  logic       flush;
  logic       ex_valid;
  logic [3:0] ex_operation;
  logic       ex_is_branch;
  logic [4:0] ex_rd;
  logic       ex_illegal;
  logic [7:0] illegal_count;

  typedef struct packed {
    logic       valid;
    logic [3:0] op;
    logic       br;
    logic [4:0] rd;
    logic       ill;
  } ex_t;

  ex_t        sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  alu_op_issue dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_aluop(id_aluop),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rd(id_rd),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_operation(ex_operation),
    .ex_is_branch(ex_is_branch), .ex_rd(ex_rd), .ex_illegal(ex_illegal),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  function automatic ex_t mk(input logic v, input logic [3:0] op, input logic br,
                             input logic [4:0] rd, input logic ill);
    mk = '{valid: v, op: op, br: br, rd: rd, ill: ill};
  endfunction

  task automatic check(input string tag);
    ex_t exp;
    ex_t got;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, nothing expected", tag);
    end else begin
      exp = sb.pop_front();
      got = {ex_valid, ex_operation, ex_is_branch, ex_rd, ex_illegal};
      assert (got === exp) else begin
        errors++;
        $error("FAIL %s: observed v=%b op=%b br=%b rd=%0d ill=%b expected v=%b op=%b br=%b rd=%0d ill=%b",
               tag, got.valid, got.op, got.br, got.rd, got.ill,
               exp.valid, exp.op, exp.br, exp.rd, exp.ill);
      end
    end
    checks++;
    assert (illegal_count === exp_cnt) else begin
      errors++;
      $error("FAIL %s_count: observed %0d expected %0d", tag, illegal_count, exp_cnt);
    end
  endtask

  // Entered and left at a falling edge; inputs change away from the rising edge.
  task automatic step(input logic v, input logic [1:0] a, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic st,
                      input logic fl, input ex_t exp, input logic bump, input string tag);
    id_valid  = v;
    id_aluop  = a;
    id_funct3 = f3;
    id_funct7 = f7;
    id_rd     = rd;
    stall     = st;
    flush     = fl;
    sb.push_back(exp);
    if (bump && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    @(posedge clk);
    @(negedge clk);
    check(tag);
  endtask

  initial begin
    ex_t add_exp;
    rst_n = 1'b0; id_valid = 1'b0; id_aluop = 2'b00; id_funct3 = 3'b000;
    id_funct7 = 7'b0; id_rd = 5'd0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    sb.push_back(mk(0, 4'b0000, 0, 5'd0, 0));
    check("reset");
    rst_n = 1'b1;

    step(1, 2'b10, 3'b000, 7'b0100000, 5'd3, 0, 0, mk(1, 4'b0011, 0, 5'd3, 0), 0, "r_sub");
    step(1, 2'b10, 3'b101, 7'b0100000, 5'd4, 0, 0, mk(1, 4'b0111, 0, 5'd4, 0), 0, "r_sra");
    step(1, 2'b10, 3'b110, 7'b0000000, 5'd5, 0, 0, mk(1, 4'b0001, 0, 5'd5, 0), 0, "r_or");
    step(1, 2'b10, 3'b001, 7'b0000000, 5'd6, 0, 0, mk(1, 4'b0100, 0, 5'd6, 0), 0, "r_sll");
    step(1, 2'b11, 3'b000, 7'b0100000, 5'd7, 0, 0, mk(1, 4'b0010, 0, 5'd7, 0), 0, "i_addi");
    step(1, 2'b11, 3'b101, 7'b0100000, 5'd8, 0, 0, mk(1, 4'b0111, 0, 5'd8, 0), 0, "i_srai");
    step(1, 2'b01, 3'b101, 7'b0000000, 5'd9, 0, 0, mk(1, 4'b1111, 1, 5'd9, 0), 0, "br_bge");
    step(1, 2'b01, 3'b000, 7'b0000000, 5'd1, 0, 0, mk(1, 4'b1000, 1, 5'd1, 0), 0, "br_eq");
    step(1, 2'b01, 3'b110, 7'b0000000, 5'd10, 0, 0, mk(1, 4'b0000, 1, 5'd10, 1), 1, "br_ill");
    step(1, 2'b10, 3'b000, 7'b0000001, 5'd11, 0, 0, mk(1, 4'b0000, 0, 5'd11, 1), 1, "r_bad_f7");
    step(1, 2'b11, 3'b001, 7'b0100000, 5'd13, 0, 0, mk(1, 4'b0000, 0, 5'd13, 1), 1, "i_slli_bad");
    step(0, 2'b10, 3'b000, 7'b0100000, 5'd14, 0, 0, mk(0, 4'b0000, 0, 5'd0, 0), 0, "bubble");

    add_exp = mk(1, 4'b0010, 0, 5'd12, 0);
    step(1, 2'b00, 3'b111, 7'b0000000, 5'd12, 0, 0, add_exp, 0, "mem_add");
    step(1, 2'b10, 3'b010, 7'b0000000, 5'd15, 1, 0, add_exp, 0, "stall1");
    step(1, 2'b01, 3'b000, 7'b0000000, 5'd16, 1, 0, add_exp, 0, "stall2");
    step(0, 2'b10, 3'b000, 7'b0100000, 5'd17, 1, 0, add_exp, 0, "stall3");
    step(1, 2'b10, 3'b010, 7'b0000000, 5'd18, 1, 1, mk(0, 4'b0000, 0, 5'd0, 0), 0, "stall_flush");
    step(1, 2'b10, 3'b000, 7'b0100000, 5'd19, 0, 0, mk(1, 4'b0011, 0, 5'd19, 0), 0, "reload");
    step(1, 2'b01, 3'b001, 7'b0000000, 5'd20, 0, 1, mk(0, 4'b0000, 0, 5'd0, 0), 0, "flush");

    for (int i = 0; i < 260; i++)
      step(1, 2'b10, 3'b010, 7'b0000000, 5'(i), 0, 0, mk(1, 4'b0000, 0, 5'(i), 1), 1, "sat");
    checks++;
    assert (illegal_count === 8'd255) else begin
      errors++;
      $error("FAIL sat_final: observed %0d expected 255", illegal_count);
    end

    // Asynchronous reset in the middle of a cycle while EX holds a valid instruction.
    step(1, 2'b10, 3'b101, 7'b0000000, 5'd21, 0, 0, mk(1, 4'b0101, 0, 5'd21, 0), 0, "r_srl");
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 8'd0;
    sb.push_back(mk(0, 4'b0000, 0, 5'd0, 0));
    check("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    step(1, 2'b11, 3'b100, 7'b1111111, 5'd22, 0, 0, mk(1, 4'b1101, 0, 5'd22, 0), 0, "i_xori");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
